soc_system_pio_edge_in: RTL



---
 rtl/soc_system_pio_edge_in.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/soc_system_pio_edge_in.sv
// ============================================================================
// Module   : soc_system_pio_edge_in
// Brief    : Avalon-MM input PIO with edge capture and a maskable level irq.
//            Optional per-bit debounce is enabled with `define INPUT_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_system_pio_edge_in #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;
    localparam logic [1:0] ARM_DONE     = 2'd3;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_mask;
    logic [1:0]       r_arm;
    logic             r_irq;

    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_mask_next;
    logic [WIDTH-1:0] w_cap_next;
    logic             w_wr;
    logic             w_unused;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef INPUT_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    // A bit only follows sync2 after it has disagreed for DEBOUNCE_CYCLES samples.
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        logic [CNT_W-1:0] r_cnt;
        logic             r_deb;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
                r_deb <= 1'b0;
            end else if (r_sync2[i] == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_deb <= r_sync2[i];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_filt[i] = r_deb;
    end

    assign w_unused = ^writedata;
`else
    assign w_filt   = r_sync2;
    assign w_unused = ^{writedata, 32'(DEBOUNCE_CYCLES)};
`endif

    always_comb begin
        w_rise = w_filt & ~r_prev;
        w_fall = ~w_filt & r_prev;
        case (EDGE_TYPE)
            0:       w_edge = w_rise;
            1:       w_edge = w_fall;
            default: w_edge = w_rise | w_fall;
        endcase
        // Hold off captures until the synchroniser and prev have filled after reset.
        if (r_arm != ARM_DONE) begin
            w_edge = '0;
        end
    end

    always_comb begin
        w_wr        = chipselect & ~write_n;
        w_clr       = '0;
        w_mask_next = r_mask;
        if (w_wr && (address == ADDR_EDGECAP)) begin
            w_clr = writedata[WIDTH-1:0];
        end
        if (w_wr && (address == ADDR_IRQMASK)) begin
            w_mask_next = writedata[WIDTH-1:0];
        end
        // Set wins over a same-cycle write-1-to-clear.
        w_cap_next = (r_cap & ~w_clr) | w_edge;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
            r_arm  <= '0;
            r_cap  <= '0;
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_prev <= w_filt;
            if (r_arm != ARM_DONE) begin
                r_arm <= r_arm + 2'd1;
            end
            r_cap  <= w_cap_next;
            r_mask <= w_mask_next;
            r_irq  <= |(w_cap_next & w_mask_next);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = w_filt;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = r_mask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = r_cap;
            default:      readdata = '0;
        endcase
    end

    assign irq = r_irq;

endmodule

`default_nettype wire
